// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent TX and RX engines that share one bit-period count (DIV clocks).
// RX samples mid-bit from a 2-flop synchronised copy of uart_rxd; TX frames bytes straight onto uart_txd.
module uart_txrx #(
    parameter int freq_hz = 100000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy
);

    localparam int DIV = freq_hz / baud;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // ---------------- transmitter ----------------
    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            txd_q, txd_d;
    logic            tx_busy_q, tx_busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
        unique case (tx_state_q)
            S_IDLE: begin
                if (tx_wr) begin
                    tx_shift_d = tx_data;
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_DATA;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        // Shift register keeps the bit on the wire in position 0.
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                    tx_busy_d  = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign uart_txd = txd_q;
    assign tx_busy  = tx_busy_q;

    // ---------------- receiver ----------------
    logic [1:0]      rx_sync_q;
    logic            rxs;
    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_avail_q, rx_avail_d;
    logic            rx_error_q, rx_error_d;

    assign rxs = rx_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_avail_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rxd};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_avail_q <= rx_avail_d;
            rx_error_q <= rx_error_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_error_d = 1'b0;
        // A completing byte below overrides this ack-driven clear.
        rx_avail_d = rx_ack ? 1'b0 : rx_avail_q;
        unique case (rx_state_q)
            S_IDLE: begin
                if (!rxs) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    if (rxs) begin
                        rx_data_d  = rx_shift_q;
                        rx_avail_d = 1'b1;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign rx_data  = rx_data_q;
    assign rx_avail = rx_avail_q;
    assign rx_error = rx_error_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx at DIV=43: loopback bytes, TX bit timing, busy-write drop,
// framing error, glitch rejection, mid-frame reset and overrun.
module tb_uart_txrx;

    localparam int DIV = 43;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rxd, uart_txd;
    logic [7:0] rx_data;
    logic       rx_avail, rx_error, rx_ack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0, tx_busy;
    logic       loop_en = 1'b1;
    logic       drv_rxd = 1'b1;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    assign uart_rxd = loop_en ? uart_txd : drv_rxd;

    uart_txrx #(.freq_hz(50000000), .baud(1152000)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (rx_error) err_pulses <= err_pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("tmo_busy", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_idle();
        tx_data = b;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic wait_avail();
        int n = 0;
        while (!rx_avail && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("tmo_avail", 32'd0, 32'd1);
    endtask

    task automatic do_ack();
        @(negedge clk); rx_ack = 1'b1;
        @(negedge clk); rx_ack = 1'b0;
        chk("ack_clears", 32'(rx_avail), 32'd0);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_ok);
        drv_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drv_rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        drv_rxd = stop_ok;
        // A low stop bit is cut short so its tail cannot look like a fresh start bit.
        repeat (stop_ok ? DIV : 30) @(negedge clk);
        drv_rxd = 1'b1;
    endtask

    logic       txs [0:999];
    logic [9:0] fr;
    logic [7:0] loop_bytes [4];
    int         ones, nb, e0;
    logic       any_busy, any_avail;

    initial begin
        loop_bytes[0] = 8'h00; loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'h80; loop_bytes[3] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_rxdata", 32'(rx_data), 32'd0);
        chk("rst_avail", 32'(rx_avail), 32'd0);
        chk("rst_error", 32'(rx_error), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // loopback bytes
        foreach (loop_bytes[k]) begin
            send_byte(loop_bytes[k]);
            wait_avail();
            chk("loop_data", 32'(rx_data), 32'(loop_bytes[k]));
            do_ack();
        end

        // TX bit timing for 0xA5
        wait_idle();
        repeat (10) @(negedge clk);
        tx_data = 8'hA5; tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        nb = 0;
        while (tx_busy && nb < 1000) begin
            txs[nb] = uart_txd;
            nb++;
            @(negedge clk);
        end
        chk("busy_len", 32'(nb), 32'd430);
        chk("txd_idle", 32'(uart_txd), 32'd1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ones = 0;
            for (int j = 0; j < DIV; j++) ones += int'(txs[i*DIV + j]);
            chk($sformatf("tx_bit%0d", i), 32'(ones), fr[i] ? 32'd43 : 32'd0);
        end
        wait_avail();
        chk("a5_data", 32'(rx_data), 32'hA5);
        do_ack();

        // write while busy is dropped
        send_byte(8'h96);
        repeat (100) @(negedge clk);
        tx_data = 8'h3C; tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        wait_avail();
        chk("busy_wr_data", 32'(rx_data), 32'h96);
        do_ack();
        wait_idle();
        any_busy = 1'b0; any_avail = 1'b0;
        repeat (600) begin
            @(negedge clk);
            any_busy  |= tx_busy;
            any_avail |= rx_avail;
        end
        chk("no_2nd_busy", 32'(any_busy), 32'd0);
        chk("no_2nd_avail", 32'(any_avail), 32'd0);

        // framing error
        loop_en = 1'b0;
        e0 = err_pulses;
        drive_frame(8'h55, 1'b0);
        repeat (100) @(negedge clk);
        chk("frm_err_pulses", 32'(err_pulses - e0), 32'd1);
        chk("frm_avail", 32'(rx_avail), 32'd0);

        // glitch then valid 0x12
        e0 = err_pulses;
        drv_rxd = 1'b0;
        repeat (10) @(negedge clk);
        drv_rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_avail", 32'(rx_avail), 32'd0);
        chk("glitch_err", 32'(err_pulses - e0), 32'd0);
        drive_frame(8'h12, 1'b1);
        wait_avail();
        chk("post_glitch", 32'(rx_data), 32'h12);
        do_ack();

        // reset mid-TX at bit 3
        loop_en = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'hC3);
        repeat (190) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst_txd", 32'(uart_txd), 32'd1);
        chk("mrst_busy", 32'(tx_busy), 32'd0);
        chk("mrst_rxdata", 32'(rx_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        send_byte(8'h81);
        wait_avail();
        chk("after_rst", 32'(rx_data), 32'h81);
        do_ack();

        // overrun
        send_byte(8'h11);
        send_byte(8'h22);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ovr_data", 32'(rx_data), 32'h22);
        chk("ovr_avail", 32'(rx_avail), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
